// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM states and width defaults.
package alu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_ITER  = 32;
    localparam int CNT_W     = $clog2(DEF_ITER);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_NEG  = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    // Two's-complement magnitude; the most negative value maps to 2^(W-1) unsigned.
    function automatic logic [DEF_WIDTH-1:0] mag(input logic [DEF_WIDTH-1:0] v);
        return v[DEF_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration on {A,Q,q-1} with multiplicand M.
// A carries one guard bit so that A - M cannot overflow when M is the most negative value.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_qm1,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_qm1
);

    logic [WIDTH:0] w_m_ext;
    logic [WIDTH:0] w_sum;

    assign w_m_ext = {i_m[WIDTH-1], i_m};

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_sum = i_a;
        case ({i_q[0], i_qm1})
            2'b01:   w_sum = i_a + w_m_ext;
            2'b10:   w_sum = i_a - w_m_ext;
            default: w_sum = i_a;
        endcase
    end

    assign {o_a, o_q, o_qm1} = {w_sum[WIDTH], w_sum, i_q};

endmodule

// File: rtl/alu_sequencer.sv
// Start/done sequencer for the 32-bit ALU: single-cycle ops, 32-step Booth multiply,
// and a 32-step restoring divider built only when ALU_SEQ_DIV_EN is defined.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITER  = DEF_ITER
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Zhigh,
    output logic [WIDTH-1:0] Zlow
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH-1:0] r_m;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_booth_a;
    logic [WIDTH-1:0] w_booth_q;
    logic             w_booth_qm1;
    logic [WIDTH-1:0] w_exec;
    logic [4:0]       w_shamt;
    logic [5:0]       w_inv_shamt;

`ifdef ALU_SEQ_DIV_EN
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;

    // Restoring step: shift {R,Q} left, keep R-D only when it did not go negative.
    assign w_div_shift = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_m};
    assign w_div_ge    = ~w_div_diff[WIDTH];
`endif

    booth_step #(.WIDTH(WIDTH)) u_booth (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .i_m   (r_m),
        .o_a   (w_booth_a),
        .o_q   (w_booth_q),
        .o_qm1 (w_booth_qm1)
    );

    assign w_shamt     = r_rb[4:0];
    assign w_inv_shamt = 6'(WIDTH) - {1'b0, w_shamt};

    // Single-cycle datapath on the latched operands; illegal codes return zero.
    always_comb begin
        w_exec = '0;
        case (r_op)
            OP_AND:  w_exec = r_ra & r_rb;
            OP_OR:   w_exec = r_ra | r_rb;
            OP_ADD:  w_exec = r_ra + r_rb;
            OP_SUB:  w_exec = r_ra - r_rb;
            OP_SHR:  w_exec = r_ra >> w_shamt;
            OP_SHRA: w_exec = $signed(r_ra) >>> w_shamt;
            OP_SHL:  w_exec = r_ra << w_shamt;
            OP_ROR:  w_exec = (r_ra >> w_shamt) | (r_ra << w_inv_shamt);
            OP_ROL:  w_exec = (r_ra << w_shamt) | (r_ra >> w_inv_shamt);
            OP_NEG:  w_exec = '0 - r_ra;
            OP_NOT:  w_exec = ~r_ra;
            default: w_exec = '0;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            Zhigh   <= '0;
            Zlow    <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_m     <= '0;
`ifdef ALU_SEQ_DIV_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; later writes override this default.
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_ra <= Ra;
                        r_rb <= Rb;
                        busy <= 1'b1;
                        if (op == OP_MUL) begin
                            r_state <= ST_MUL;
                            r_cnt   <= '0;
                            r_a     <= '0;
                            r_q     <= Rb;
                            r_qm1   <= 1'b0;
                            r_m     <= Ra;
                        end
`ifdef ALU_SEQ_DIV_EN
                        else if (op == OP_DIV) begin
                            if (Rb == '0) begin
                                r_state <= ST_DONE;
                                done    <= 1'b1;
                                Zlow    <= '1;
                                Zhigh   <= Ra;
                            end else begin
                                r_state <= ST_DIV;
                                r_cnt   <= '0;
                                r_a     <= '0;
                                r_q     <= mag(Ra);
                                r_m     <= mag(Rb);
                                r_neg_q <= Ra[WIDTH-1] ^ Rb[WIDTH-1];
                                r_neg_r <= Ra[WIDTH-1];
                            end
                        end
`endif
                        else begin
                            r_state <= ST_EXEC;
                        end
                    end
                end

                ST_EXEC: begin
                    Zhigh   <= '0;
                    Zlow    <= w_exec;
                    done    <= 1'b1;
                    r_state <= ST_DONE;
                end

                ST_MUL: begin
                    r_a   <= w_booth_a;
                    r_q   <= w_booth_q;
                    r_qm1 <= w_booth_qm1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_STEP) begin
                        Zhigh   <= w_booth_a[WIDTH-1:0];
                        Zlow    <= w_booth_q;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

`ifdef ALU_SEQ_DIV_EN
                ST_DIV: begin
                    r_a   <= w_div_ge ? w_div_diff : w_div_shift;
                    r_q   <= {r_q[WIDTH-2:0], w_div_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_state <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    Zlow    <= r_neg_q ? ('0 - r_q) : r_q;
                    Zhigh   <= r_neg_r ? ('0 - r_a[WIDTH-1:0]) : r_a[WIDTH-1:0];
                    done    <= 1'b1;
                    r_state <= ST_DONE;
                end
`endif

                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer; expectations come from a behavioural model.
// Divider cases follow the ALU_SEQ_DIV_EN build option.
module tb_alu_sequencer;

    logic        clock;
    logic        clear;
    logic        start;
    logic [3:0]  op;
    logic [31:0] Ra;
    logic [31:0] Rb;
    logic        busy;
    logic        done;
    logic [31:0] Zhigh;
    logic [31:0] Zlow;

    typedef struct {
        string       tag;
        logic [31:0] zh;
        logic [31:0] zl;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    alu_sequencer dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .op    (op),
        .Ra    (Ra),
        .Rb    (Rb),
        .busy  (busy),
        .done  (done),
        .Zhigh (Zhigh),
        .Zlow  (Zlow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) if (done === 1'b1) n_done++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioural reference: {Zhigh, Zlow} for one operation.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        r;
        logic signed [63:0] p;
        int                 sh;
        int                 sa;
        int                 sbv;
        sh = int'(b[4:0]);
        r  = a;
        case (o)
            4'd0:  return {32'h0, a & b};
            4'd1:  return {32'h0, a | b};
            4'd2:  return {32'h0, a + b};
            4'd3:  return {32'h0, a - b};
            4'd4:  return {32'h0, a >> sh};
            4'd5: begin
                for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
                return {32'h0, r};
            end
            4'd6:  return {32'h0, a << sh};
            4'd7: begin
                for (int i = 0; i < sh; i++) r = {r[0], r[31:1]};
                return {32'h0, r};
            end
            4'd8: begin
                for (int i = 0; i < sh; i++) r = {r[30:0], r[31]};
                return {32'h0, r};
            end
            4'd9:  return {32'h0, 32'h0 - a};
            4'd10: return {32'h0, ~a};
            4'd11: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p;
            end
`ifdef ALU_SEQ_DIV_EN
            4'd12: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                sa  = a;
                sbv = b;
                return {32'(sa % sbv), 32'(sa / sbv)};
            end
`endif
            default: return 64'h0;
        endcase
    endfunction

    // Drives one start pulse from a negedge; returns on the negedge after the accepting edge
    // with fresh garbage on the operand inputs.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        Ra    = a;
        Rb    = b;
        @(negedge clock);
        start = 1'b0;
        op    = 4'($urandom);
        Ra    = $urandom;
        Rb    = $urandom;
    endtask

    task automatic push(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat);
        exp_t        e;
        logic [63:0] m;
        m     = model(o, a, b);
        e.tag = tag;
        e.zh  = m[63:32];
        e.zl  = m[31:0];
        e.lat = lat;
        sb.push_back(e);
    endtask

    // Waits (bounded) for done, pops the scoreboard and checks result, latency and return to IDLE.
    task automatic complete(input string tag, input int lat0);
        int   lat;
        exp_t e;
        lat = lat0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_latency"}, 64'(lat), 64'(e.lat));
            check({e.tag, "_zhigh"}, {32'h0, Zhigh}, {32'h0, e.zh});
            check({e.tag, "_zlow"}, {32'h0, Zlow}, {32'h0, e.zl});
        end
        @(negedge clock);
        check({tag, "_idle_busy"}, {63'h0, busy}, 64'd0);
        check({tag, "_idle_done"}, {63'h0, done}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat);
        push(tag, o, a, b, lat);
        issue(o, a, b);
        complete(tag, 0);
    endtask

    initial begin
        int d0;
        clear = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        Ra    = 32'h0;
        Rb    = 32'h0;
        repeat (2) @(negedge clock);
        check("reset_busy", {63'h0, busy}, 64'd0);
        check("reset_done", {63'h0, done}, 64'd0);
        check("reset_z", {Zhigh, Zlow}, 64'd0);
        clear = 1'b0;
        @(negedge clock);

        // Logic ops: AAAAAAAA & 55555555 = 0, | = FFFFFFFF.
        run_op("and", 4'd0, 32'hAAAA_AAAA, 32'h5555_5555, 1);
        run_op("or", 4'd1, 32'hAAAA_AAAA, 32'h5555_5555, 1);
        run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1);
        run_op("sub_wrap", 4'd3, 32'h0000_0000, 32'h0000_0001, 1);

        // Shifts/rotates: SHRA 80000000>>>4 = F8000000, ROL 12345678 by 8 = 34567812.
        run_op("shra", 4'd5, 32'h8000_0000, 32'd4, 1);
        run_op("rol", 4'd8, 32'h1234_5678, 32'd8, 1);
        run_op("shl_zero", 4'd6, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 1);
        run_op("shr", 4'd4, 32'h8000_0001, 32'd31, 1);
        run_op("ror", 4'd7, 32'h1234_5678, 32'd4, 1);
        run_op("ror_zero", 4'd7, 32'hCAFE_F00D, 32'd0, 1);
        run_op("neg", 4'd9, 32'h0000_0005, 32'h0, 1);
        run_op("not", 4'd10, 32'h0F0F_1234, 32'h0, 1);
        run_op("illegal", 4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 1);

        // Multiply: -3*7 = FFFFFFFF_FFFFFFEB, (-2^31)^2 = 40000000_00000000.
        run_op("mul_neg", 4'd11, 32'hFFFF_FFFD, 32'd7, 32);
        run_op("mul_min", 4'd11, 32'h8000_0000, 32'h8000_0000, 32);
        run_op("mul_mixed", 4'd11, 32'h1234_5678, 32'hFEDC_BA98, 32);

        // Handshake: ADD pulsed mid-MUL must be dropped; exactly one done pulse.
        d0 = n_done;
        push("mul_busy", 4'd11, 32'd5, 32'd6, 32);
        issue(4'd11, 32'd5, 32'd6);
        repeat (5) @(negedge clock);
        start = 1'b1;
        op    = 4'd2;
        Ra    = 32'd1;
        Rb    = 32'd1;
        @(negedge clock);
        start = 1'b0;
        complete("mul_busy", 6);
        repeat (3) @(negedge clock);
        #1;
        check("busy_single_done", 64'(n_done - d0), 64'd1);

`ifdef ALU_SEQ_DIV_EN
        // -7/2 -> q=-3, r=-1; 5/0 -> FFFFFFFF with remainder 5, done right after acceptance.
        run_op("div_neg", 4'd12, 32'hFFFF_FFF9, 32'd2, 33);
        run_op("div_zero", 4'd12, 32'd5, 32'd0, 0);
        run_op("div_mixed", 4'd12, 32'd100, 32'hFFFF_FFF9, 33);
`else
        run_op("div_absent", 4'd12, 32'hFFFF_FFF9, 32'd2, 1);
`endif

        // Clear 10 cycles into a MUL: everything returns to reset values, then an AND works.
        run_op("pre_clear", 4'd10, 32'h0, 32'h0, 1);
        issue(4'd11, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        repeat (10) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check("clear_busy", {63'h0, busy}, 64'd0);
        check("clear_done", {63'h0, done}, 64'd0);
        check("clear_z", {Zhigh, Zlow}, 64'd0);
        clear = 1'b0;
        @(negedge clock);
        run_op("and_after_clear", 4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Sequencing controller for the 32-bit ALU datapath. It sits between the CPU control unit and the combinational units (and32, or32, add/sub, shifters).
- Accepts one operation per start/done handshake.
- Single-cycle ops are dispatched to the combinational units and their result is registered.
- Signed multiply (radix-2 Booth) and, optionally, signed divide are iterated over 32 cycles.
- Results are returned on the Zhigh/Zlow pair that feeds the Z register.

Parameters:
WIDTH, 32, operand width. Only 32 is supported; the parameter exists for package consistency.
ITER, 32, iteration count for MUL/DIV. Must equal WIDTH.

Ports:
clock  input  1  system clock, rising-edge.
clear  input  1  asynchronous, active-high reset.
start  input  1  request strobe. Sampled only in IDLE.
op  input  4  operation code. Sampled with start.
Ra  input  32  operand A. Sampled with start.
Rb  input  32  operand B or shift amount (Rb[4:0]). Sampled with start.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; Zhigh/Zlow are valid while it is high.
Zhigh  output  32  upper result: MUL high word, DIV remainder, else 0.
Zlow  output  32  lower result.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (clear). On clear:
  - state=IDLE;
  - busy=0, done=0;
  - Zhigh=0, Zlow=0;
  - iteration counter=0.
- Op codes:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 MUL, 12 DIV.
  - 13-15 are illegal.
- Arithmetic rules:
  - Shift/rotate amount is Rb[4:0]; an amount of 0 returns Ra.
  - ADD/SUB wrap modulo 2^32, and carry is discarded.
  - NEG = 0-Ra. NOT = ~Ra.
- States: IDLE, EXEC, MUL, DIV, FIX, DONE.
- IDLE:
  - On an edge with start=1, op/Ra/Rb are latched.
  - Single-cycle and illegal ops go to EXEC. MUL goes to MUL with counter=0. DIV goes to DIV, or to DONE if Rb==0.
- EXEC: result registered on the next edge, then go to DONE. done goes high one cycle after EXEC, i.e. the 2nd cycle after the accepting edge.
- MUL:
  - One Booth step per edge on the {A,Q,q-1} register.
  - After the 32nd step, {Zhigh,Zlow} = signed Ra*Rb, then go to DONE.
  - done is high in the cycle after edge k+32, where k is the accepting edge.
- DIV: restoring division on magnitudes, 32 steps, then go to FIX.
- FIX:
  - Applies signs: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Zlow=quotient, Zhigh=remainder, then go to DONE.
- DONE: done=1 for exactly one cycle, Zhigh/Zlow held. Next edge goes to IDLE with busy=0.
- Outputs hold their last values until the next result write.
- start while busy is ignored and not queued.
- start held high continuously issues back-to-back ops, with one IDLE cycle between each.
- Illegal op: Zhigh=Zlow=0, same timing as a single-cycle op.
- Divide by zero: Zlow=32'hFFFFFFFF, Zhigh=Ra, no iteration, done in the cycle after the accepting edge.
- clear asserted mid-operation aborts immediately to reset values. No partial result is visible.
- Operand changes after acceptance have no effect.

Optional Feature:
ALU_SEQ_DIV_EN
- Defined: the DIV and FIX states, the divider datapath and op 12 exist as described above.
- Undefined: no divider logic is built, and op 12 is handled as an illegal op (Zhigh=Zlow=0, single-cycle timing).

Decomposition:
- Shared package alu_pkg holds:
  - op-code localparams (OP_AND..OP_DIV);
  - the state enumeration;
  - WIDTH/ITER defaults.
- One sub-module, booth_step: combinational single Booth iteration.
  - Inputs {A,Q,q-1} and M; output is the next {A,Q,q-1}.
  - Instantiated once.
- Single-cycle ops instantiate the existing combinational ALU units.

Test Plan:
- Reset: clear mid-MUL (10 cycles after start) -> busy=0, done=0, Zhigh=Zlow=0 next cycle. A new AND then completes normally.
- Logic ops:
  - AND Ra=AAAAAAAA, Rb=55555555 -> Zlow=00000000, Zhigh=0.
  - OR same operands -> Zlow=FFFFFFFF.
  - done 2 cycles after start.
- Shifts:
  - SHRA Ra=80000000, Rb=4 -> F8000000.
  - ROL Ra=12345678, Rb=8 -> 34567812.
  - SHL Rb=0 -> Ra.
- MUL:
  - Ra=FFFFFFFD (-3), Rb=7 -> Zhigh=FFFFFFFF, Zlow=FFFFFFEB.
  - Ra=Rb=80000000 -> Zhigh=40000000, Zlow=0.
  - done exactly 33 cycles after the accepting edge.
- Handshake: start pulsed with ADD 1+1 during a busy MUL -> ignored; only the MUL result appears and done pulses once.
- DIV (ALU_SEQ_DIV_EN):
  - -7/2 -> Zlow=FFFFFFFD, Zhigh=FFFFFFFF.
  - 5/0 -> Zlow=FFFFFFFF, Zhigh=5.
  - Without the macro, op 12 -> zeros with single-cycle timing.
